parity_serial_tx: RTL and testbench



---
 rtl/parity_serial_tx.sv | 117 +++++++++++
 tb/tb_parity_serial_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: serial word transmitter with an appended parity bit.
//
// Accepts a DATA_W-bit word over a valid/ready handshake. It shifts the word
// out LSB-first on o_x, one bit per clock, and then sends one parity bit.
// A word accepted during the parity slot starts on the next cycle, so
// back-to-back frames have no idle gap.
//
// Configuration macro:
//   PARITY_TX_ODD_EN  undefined (default): even parity, parity bit = ^data.
//                     defined: odd parity, parity bit = ~^data.
//
// Ports:
//   i_clk    clock; all state updates on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_data   parallel word; sampled only on an accepted handshake
//   i_valid  i_data is valid this cycle
//   o_ready  a word can be accepted this cycle (idle or parity slot)
//   o_x      serial line
//   o_frame  high while o_x carries a data or parity bit
//   o_par    high during the parity slot only
module parity_serial_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_x,
  output logic              o_frame,
  output logic              o_par
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;
  logic [CntW-1:0]   cnt_q;
  logic              x_q;
  logic              frame_q;
  logic              par_q;

  logic              accept;
  logic              par_load;
  logic [DATA_W-1:0] shift_nxt;

  assign o_ready   = (state_q == StIdle) || (state_q == StParity);
  assign accept    = i_valid && o_ready;
  assign shift_nxt = shift_q >> 1;

`ifdef PARITY_TX_ODD_EN
  assign par_load = ~^i_data;
`else
  assign par_load = ^i_data;
`endif

  // The serial outputs are registered copies of what the current state
  // drives, so they only move on a rising edge or on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      x_q      <= 1'b0;
      frame_q  <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StData: begin
          shift_q <= shift_nxt;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            // Last data bit has just been sent; move to the parity slot.
            state_q <= StParity;
            x_q     <= parity_q;
            frame_q <= 1'b1;
            par_q   <= 1'b1;
          end else begin
            x_q     <= shift_nxt[0];
            frame_q <= 1'b1;
            par_q   <= 1'b0;
          end
        end
        default: begin
          // StIdle and StParity: both can accept a new word.
          if (accept) begin
            state_q  <= StData;
            shift_q  <= i_data;
            parity_q <= par_load;
            cnt_q    <= '0;
            x_q      <= i_data[0];
            frame_q  <= 1'b1;
            par_q    <= 1'b0;
          end else begin
            state_q <= StIdle;
            x_q     <= 1'b0;
            frame_q <= 1'b0;
            par_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_x     = x_q;
  assign o_frame = frame_q;
  assign o_par   = par_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Testbench for parity_serial_tx (DATA_W = 8). Expected per-cycle outputs are
// queued when a word is driven and popped one per clock after each edge.
module tb_parity_serial_tx;

  localparam int DW = 8;
`ifdef PARITY_TX_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic          o_x;
  logic          o_frame;
  logic          o_par;

  parity_serial_tx #(
    .DATA_W(DW)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_x    (o_x),
    .o_frame(o_frame),
    .o_par  (o_par)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic x;
    logic frame;
    logic par;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          even_par;  // hand-computed even-parity bit
  } vec_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0b, expected %0b", name, $time, act, req);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input logic p);
    for (int i = 0; i < DW; i++) exp_q.push_back('{x: d[i], frame: 1'b1, par: 1'b0});
    exp_q.push_back('{x: p, frame: 1'b1, par: 1'b1});
  endtask

  // Advance one clock and compare outputs against the next queued slot,
  // or against idle outputs when nothing is queued.
  task automatic tick();
    exp_t e;
    logic rdy;
    @(posedge i_clk);
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      rdy = e.par;
    end else begin
      e   = '0;
      rdy = 1'b1;
    end
    chk("o_x", o_x, e.x);
    chk("o_frame", o_frame, e.frame);
    chk("o_par", o_par, e.par);
    chk("o_ready", o_ready, rdy);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic even_p);
    i_data  = d;
    i_valid = 1'b1;
    push_frame(d, even_p ^ ODD);
    tick();
    i_valid = 1'b0;
    repeat (DW) tick();
    tick();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h3C, 1'b0};
    vecs[3] = '{8'h5A, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b0};
    vecs[6] = '{8'h01, 1'b1};
    vecs[7] = '{8'h80, 1'b1};
    vecs[8] = '{8'h6E, 1'b1};

    // Reset held with valid asserted: idle outputs, nothing starts.
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'hA5;
    repeat (3) tick();
    i_rst_n = 1'b1;

    // First accept after release starts a frame; then the table.
    for (int k = 0; k < 9; k++) send_word(vecs[k].data, vecs[k].even_par);

    // Back-to-back: 01 then 80 with valid held high.
    i_data  = 8'h01;
    i_valid = 1'b1;
    push_frame(8'h01, 1'b1 ^ ODD);
    push_frame(8'h80, 1'b1 ^ ODD);
    tick();
    i_data = 8'h80;
    repeat (DW) tick();
    tick();
    i_valid = 1'b0;
    repeat (DW) tick();
    tick();

    // Input isolation: data changes and a valid pulse mid-frame are ignored.
    i_data  = 8'hFF;
    i_valid = 1'b1;
    push_frame(8'hFF, 1'b0 ^ ODD);
    tick();
    i_data  = 8'h00;
    i_valid = 1'b0;
    tick();
    tick();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (DW - 3) tick();
    tick();
    tick();

    // Reset mid-frame: outputs drop asynchronously, no parity bit follows.
    i_data  = 8'hA5;
    i_valid = 1'b1;
    push_frame(8'hA5, 1'b0 ^ ODD);
    tick();
    i_valid = 1'b0;
    repeat (3) tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_o_frame", o_frame, 1'b0);
    chk("async_rst_o_x", o_x, 1'b0);
    chk("async_rst_o_par", o_par, 1'b0);
    chk("async_rst_o_ready", o_ready, 1'b1);
    exp_q.delete();
    tick();
    tick();
    i_rst_n = 1'b1;
    send_word(8'h3C, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
